// File: rtl/oam_dma_pkg.sv
// oam_dma_pkg: shared state encoding, bus constants and address helper for the OAM DMA engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package oam_dma_pkg;

  // FSM states of the transfer engine
  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  // CPU write to this address starts a transfer
  localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
  // every DMA byte is written to the PPU OAMDATA port
  localparam logic [15:0] DMA_OAM_PORT  = 16'h2004;

  // Source address of byte idx within page; idx never carries into page.
  function automatic logic [15:0] page_addr(input logic [7:0] page, input logic [7:0] idx);
    return {page, idx};
  endfunction

endpackage

// File: rtl/oam_dma.sv
// oam_dma: CPU-side OAM DMA, copies page $XX00-$XXFF to OAMDATA on a $4014 write.
// Latency: CPU_HALT rises one Clk after the trigger CE; 513/514 halted CE per transfer.
// Backpressure: none; all state advances only on CPU_CE and holds while CPU_CE=0.
// Optional: define OAMDMA_PERF_CNT_EN to add the DBG_CYCLES transfer-length counter.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] OAM_PORT  = DMA_OAM_PORT,
  parameter logic [15:0] TRIG_ADDR = DMA_TRIG_ADDR
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        CPU_CE,
  input  logic [15:0] ADDR,
  input  logic        CPU_WR,
  input  logic [7:0]  CPU_DO,
  input  logic [7:0]  BUS_DATA,
  output logic        DMA,
  output logic [15:0] DMA_ADDR,
  output logic        DMA_WR,
  output logic [7:0]  DMA_DO,
  output logic        CPU_HALT
`ifdef OAMDMA_PERF_CNT_EN
  ,
  output logic [15:0] DBG_CYCLES
`endif
);

  dma_state_t  state_q;
  logic [7:0]  page_q;
  logic [7:0]  idx_q;
  logic [7:0]  idx_d;
  logic        parity_q;
  logic        dma_q;
  logic [15:0] addr_q;
  logic        wr_q;
  logic [7:0]  do_q;
  logic        halt_q;
  logic        trig_hit;
  logic        last_byte;

  // Trigger is a CPU write to the trigger address; only honoured while idle.
  assign trig_hit  = (state_q == IDLE) && (ADDR == TRIG_ADDR) && !CPU_WR;
  assign idx_d     = idx_q + 8'd1;
  assign last_byte = (idx_q == 8'hFF);

  // Transfer FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      parity_q <= 1'b0;
      dma_q    <= 1'b0;
      addr_q   <= 16'h0000;
      wr_q     <= 1'b1;
      do_q     <= 8'h00;
      halt_q   <= 1'b0;
    end else if (CPU_CE) begin
      // parity runs freely so alignment depends on absolute CPU cycle count
      parity_q <= ~parity_q;
      case (state_q)
        IDLE: begin
          if (trig_hit) begin
            page_q  <= CPU_DO;
            idx_q   <= 8'h00;
            state_q <= HALT;
            halt_q  <= 1'b1;
            dma_q   <= 1'b0;
          end
        end
        HALT: begin
          // parity_q here is the parity the HALT cycle landed on; an odd one
          // needs one extra ALIGN cycle so reads fall on the right phase.
          if (!parity_q) begin
            state_q <= READ;
            dma_q   <= 1'b1;
            addr_q  <= page_addr(page_q, idx_q);
            wr_q    <= 1'b1;
          end else begin
            state_q <= ALIGN;
          end
        end
        ALIGN: begin
          state_q <= READ;
          dma_q   <= 1'b1;
          addr_q  <= page_addr(page_q, idx_q);
          wr_q    <= 1'b1;
        end
        READ: begin
          // read return is valid on the closing CE of the read cycle
          do_q    <= BUS_DATA;
          state_q <= WRITE;
          addr_q  <= OAM_PORT;
          wr_q    <= 1'b0;
        end
        WRITE: begin
          idx_q <= idx_d;
          if (last_byte) begin
            state_q <= IDLE;
            dma_q   <= 1'b0;
            halt_q  <= 1'b0;
            addr_q  <= 16'h0000;
            wr_q    <= 1'b1;
          end else begin
            state_q <= READ;
            addr_q  <= page_addr(page_q, idx_d);
            wr_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          dma_q   <= 1'b0;
          halt_q  <= 1'b0;
          wr_q    <= 1'b1;
        end
      endcase
    end
  end

  assign DMA      = dma_q;
  assign DMA_ADDR = addr_q;
  assign DMA_WR   = wr_q;
  assign DMA_DO   = do_q;
  assign CPU_HALT = halt_q;

`ifdef OAMDMA_PERF_CNT_EN
  logic [15:0] cycles_q;

  // Counts halted CE cycles of the current transfer; holds until next trigger.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cycles_q <= 16'h0000;
    end else if (CPU_CE) begin
      if (trig_hit) begin
        cycles_q <= 16'h0000;
      end else if (state_q != IDLE) begin
        cycles_q <= cycles_q + 16'd1;
      end
    end
  end

  assign DBG_CYCLES = cycles_q;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: randomized self-checking bench for oam_dma against a page-copy reference model.
// Latency: checks 513/514 halted CE per transfer depending on trigger parity.
// Backpressure: exercises CPU_CE gaps, during which all outputs must hold.
`timescale 1ns/1ps
module tb_oam_dma;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        CPU_CE;
  logic [15:0] ADDR;
  logic        CPU_WR;
  logic [7:0]  CPU_DO;
  logic [7:0]  BUS_DATA;
  logic        DMA;
  logic [15:0] DMA_ADDR;
  logic        DMA_WR;
  logic [7:0]  DMA_DO;
  logic        CPU_HALT;
`ifdef OAMDMA_PERF_CNT_EN
  logic [15:0] DBG_CYCLES;
`endif

  logic [7:0] mem [0:65535];
  int n_cmp = 0;
  int n_bad = 0;
  bit ce_par;   // parity of the next CE, counted from reset

  logic        s_dma, s_wr, s_halt;
  logic [15:0] s_addr;
  logic [7:0]  s_do;

  typedef struct packed {
    logic [15:0] a;
    logic        wr;
    logic [7:0]  d;
  } bus_t;
  bus_t dq[$];

  always #5 Clk = ~Clk;

  // system bus model: DMA address selects the source while DMA owns the bus
  assign BUS_DATA = DMA ? mem[DMA_ADDR] : mem[ADDR];

  oam_dma dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .CPU_CE   (CPU_CE),
    .ADDR     (ADDR),
    .CPU_WR   (CPU_WR),
    .CPU_DO   (CPU_DO),
    .BUS_DATA (BUS_DATA),
    .DMA      (DMA),
    .DMA_ADDR (DMA_ADDR),
    .DMA_WR   (DMA_WR),
    .DMA_DO   (DMA_DO),
    .CPU_HALT (CPU_HALT)
`ifdef OAMDMA_PERF_CNT_EN
    ,
    .DBG_CYCLES (DBG_CYCLES)
`endif
  );

  // present a CE cycle and sample the outputs seen during it
  task automatic ce_begin(input logic [15:0] a, input logic wr, input logic [7:0] d);
    ADDR   = a;
    CPU_WR = wr;
    CPU_DO = d;
    CPU_CE = 1'b1;
    @(negedge Clk);
    s_dma  = DMA;
    s_addr = DMA_ADDR;
    s_wr   = DMA_WR;
    s_do   = DMA_DO;
    s_halt = CPU_HALT;
  endtask

  // close the CE cycle, then idle for gap clocks with a bogus trigger on the bus
  task automatic ce_end(input int gap);
    logic [26:0] snap;
    @(posedge Clk);
    #1;
    ce_par = Reset ? 1'b0 : ~ce_par;
    CPU_CE = 1'b0;
    ADDR   = 16'h4014;
    CPU_WR = 1'b0;
    CPU_DO = 8'h5A;
    snap   = {DMA, DMA_ADDR, DMA_WR, DMA_DO, CPU_HALT};
    repeat (gap) begin
      @(negedge Clk);
      n_cmp++;
      if ({DMA, DMA_ADDR, DMA_WR, DMA_DO, CPU_HALT} !== snap) begin
        n_bad++;
        $display("FAIL gap_hold: got %h required %h", {DMA, DMA_ADDR, DMA_WR, DMA_DO, CPU_HALT}, snap);
      end
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic ce(input logic [15:0] a, input logic wr, input logic [7:0] d, input int gap);
    ce_begin(a, wr, d);
    ce_end(gap);
  endtask

  // Full transfer against the model: expected bus trace is 256 (read page+k, write OAM mem[page+k]).
  task automatic run_transfer(input string name, input logic [7:0] page, input bit par,
                              input int gap, input bit poke_trig);
    int halted, nondma, errs, first_bad;
    bit done;
    bus_t want, got;
    logic [15:0] a;
    logic wr;
    dq.delete();
    if (ce_par != par) ce(16'h0000, 1'b1, 8'h00, gap);
    ce(16'h4014, 1'b0, page, gap);
    halted = 0; nondma = 0; done = 0;
    for (int n = 0; n < 600 && !done; n++) begin
      a  = 16'($urandom) & 16'h3FFF;
      wr = 1'($urandom_range(0, 1));
      if (poke_trig && n < 500 && $urandom_range(0, 3) == 0) begin
        a  = 16'h4014;
        wr = 1'b0;
      end
      ce_begin(a, wr, 8'($urandom));
      if (!s_halt && !s_dma) done = 1;
      else begin
        if (s_halt) halted++;
        if (s_halt && !s_dma) nondma++;
        if (s_dma) dq.push_back({s_addr, s_wr, s_do});
      end
      ce_end(gap);
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s_timeout: got no end of transfer within 600 CE, required end", name);
    end
    n_cmp++;
    if (halted != (par ? 513 : 514)) begin
      n_bad++;
      $display("FAIL %s_halted: got %0d required %0d", name, halted, par ? 513 : 514);
    end
    n_cmp++;
    if (nondma != (par ? 1 : 2)) begin
      n_bad++;
      $display("FAIL %s_dummy: got %0d required %0d", name, nondma, par ? 1 : 2);
    end
    n_cmp++;
    if (dq.size() != 512) begin
      n_bad++;
      $display("FAIL %s_len: got %0d required 512", name, dq.size());
    end
    errs = 0; first_bad = -1; want = '0; got = '0;
    for (int i = 0; i < 512 && i < dq.size(); i++) begin
      bus_t w;
      logic [15:0] src;
      src = {page, 8'(i / 2)};
      if (i % 2 == 0) w = {src, 1'b1, dq[i].d};
      else            w = {16'h2004, 1'b0, mem[src]};
      if (dq[i] !== w) begin
        if (first_bad < 0) begin first_bad = i; want = w; got = dq[i]; end
        errs++;
      end
    end
    n_cmp++;
    if (errs != 0) begin
      n_bad++;
      $display("FAIL %s_seq: %0d bad cycles, first #%0d got %h required %h", name, errs, first_bad, got, want);
    end
    n_cmp++;
    if (DMA !== 1'b0 || CPU_HALT !== 1'b0 || DMA_WR !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_end: got dma=%b halt=%b wr=%b required 0 0 1", name, DMA, CPU_HALT, DMA_WR);
    end
`ifdef OAMDMA_PERF_CNT_EN
    n_cmp++;
    if (DBG_CYCLES !== 16'(par ? 513 : 514)) begin
      n_bad++;
      $display("FAIL %s_perf: got %0d required %0d", name, DBG_CYCLES, par ? 513 : 514);
    end
`endif
  endtask

  task automatic test_reset;
    Reset = 1'b1; CPU_CE = 1'b0; ADDR = 16'h0000; CPU_WR = 1'b1; CPU_DO = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    // trigger presented together with reset: reset must win
    ce(16'h4014, 1'b0, 8'h33, 0);
    n_cmp++;
    if ({DMA, DMA_ADDR, DMA_WR, DMA_DO, CPU_HALT} !== {1'b0, 16'h0000, 1'b1, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_vals: got %h required %h", {DMA, DMA_ADDR, DMA_WR, DMA_DO, CPU_HALT},
               {1'b0, 16'h0000, 1'b1, 8'h00, 1'b0});
    end
`ifdef OAMDMA_PERF_CNT_EN
    n_cmp++;
    if (DBG_CYCLES !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_perf: got %0d required 0", DBG_CYCLES);
    end
`endif
    Reset = 1'b0;
    ce(16'h0000, 1'b1, 8'h00, 0);
    n_cmp++;
    if (DMA !== 1'b0 || CPU_HALT !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_trig_ignored: got dma=%b halt=%b required 0 0", DMA, CPU_HALT);
    end
  endtask

  task automatic test_no_trigger;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) ce(16'h4014, 1'b1, 8'($urandom), i % 3);
      else            ce(16'h4015, 1'b0, 8'($urandom), i % 3);
      n_cmp++;
      if (DMA !== 1'b0 || CPU_HALT !== 1'b0) begin
        n_bad++;
        $display("FAIL no_trigger_%0d: got dma=%b halt=%b required 0 0", i, DMA, CPU_HALT);
      end
    end
  endtask

  task automatic test_page_ff;
    int zero_hits;
    run_transfer("page_ff", 8'hFF, 1'($urandom_range(0, 1)), 0, 0);
    n_cmp++;
    if (dq.size() < 511 || dq[510].a !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL page_ff_last: got %h required ffff", dq.size() > 510 ? dq[510].a : 16'hxxxx);
    end
    zero_hits = 0;
    foreach (dq[i]) if (dq[i].a == 16'h0000) zero_hits++;
    n_cmp++;
    if (zero_hits != 0) begin
      n_bad++;
      $display("FAIL page_ff_wrap: got %0d accesses at 0000 required 0", zero_hits);
    end
  endtask

  task automatic test_reset_mid;
    int wcnt, idle_bad;
    bit hit;
    ce(16'h4014, 1'b0, 8'h07, 0);
    wcnt = 0; hit = 0;
    for (int n = 0; n < 600 && !hit; n++) begin
      ce_begin(16'($urandom) & 16'h3FFF, 1'b1, 8'h00);
      if (s_dma && !s_wr) begin
        if (wcnt == 128) begin
          Reset = 1'b1;
          hit = 1;
        end
        wcnt++;
      end
      ce_end(0);
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL reset_mid_reach: got %0d writes required write idx 80", wcnt);
    end
    n_cmp++;
    if ({DMA, DMA_ADDR, DMA_WR, DMA_DO, CPU_HALT} !== {1'b0, 16'h0000, 1'b1, 8'h00, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid_vals: got %h required %h", {DMA, DMA_ADDR, DMA_WR, DMA_DO, CPU_HALT},
               {1'b0, 16'h0000, 1'b1, 8'h00, 1'b0});
    end
    Reset = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      ce_begin(16'($urandom) & 16'h3FFF, 1'b0, 8'($urandom));
      if (s_dma || s_halt) idle_bad++;
      ce_end(0);
    end
    n_cmp++;
    if (idle_bad != 0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: got %0d busy CE required 0", idle_bad);
    end
    run_transfer("reset_restart", 8'h07, 1'($urandom_range(0, 1)), 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
    ce_par = 1'b0;
    test_reset();
    test_no_trigger();
    run_transfer("page02_odd", 8'h02, 1'b1, 0, 0);
    run_transfer("page02_even", 8'h02, 1'b0, 0, 0);
    test_page_ff();
    run_transfer("ce_gaps", 8'($urandom), 1'($urandom_range(0, 1)), 3, 0);
    run_transfer("retrigger", 8'h40, 1'($urandom_range(0, 1)), 1, 1);
    test_reset_mid();
    test_no_trigger();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
